lsu_ram_master: RTL and testbench
=================================

# lsu_ram_master

Initiator side of the simulation RAM port: accepts one load/store request at a time from the pipeline and drives the 64-bit, 8-byte-aligned RAM port (raddr/rdata, waddr/wdata/wstrb/wen). Performs byte-lane alignment, write-strobe generation, and load extraction with sign/zero extension. Returns a single response per request. Sits between the execute/memory stage and the DPI-backed RAM controller.

## Interface
- ADDR_W, 64, request and RAM address width
- clock  in  1  sole clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  byte address
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0=B, 1=H, 2=W, 3=D
- req_unsigned  in  1  zero-extend load (ignored for stores and D)
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  64  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned access; no RAM access performed
- ram_raddr  out  64  aligned read address
- ram_rdata  in  64  RAM read data, valid the cycle after raddr is presented
- ram_waddr  out  64  aligned write address
- ram_wdata  out  64  lane-shifted store data
- ram_wstrb  out  8  byte strobes
- ram_wen  out  1  write commit at this posedge

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch addr/wen/size/unsigned/wdata. Misaligned (addr mod 2^size ≠ 0) → RESP, resp_err=1. Else → ISSUE.
- ISSUE: store → ram_wen=1 for exactly this cycle, → RESP. Load → ram_raddr = latched aligned address, → WAIT.
- WAIT: capture ram_rdata, extract, → RESP.
- RESP: resp_valid=1, outputs held stable until resp_ready; on resp_valid&&resp_ready → IDLE. No new request is accepted in the handoff cycle.
- Alignment: aligned = addr & ~7; off = addr[2:0]; ram_wstrb = ((1<<(1<<size))-1) << off; ram_wdata = wdata << 8*off.
- Load: raw = rdata >> 8*off; keep low 8<<size bits; sign-extend from top kept bit unless req_unsigned or size=3.
- ram_raddr/ram_waddr always show the latched aligned address. ram_wstrb=0 whenever ram_wen=0.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_raddr=0, ram_waddr=0, ram_wdata=0, ram_wstrb=0, ram_wen=0.
- Accept at edge T. Latency to resp_valid: load T+3, store T+2, error T+1.
- ram_wen is gated by !reset: no write commits in any cycle where reset=1, even in ISSUE.
- Reset mid-operation: next cycle IDLE, pending request dropped, no response.
- resp_ready low stalls in RESP indefinitely. The RAM port stays quiet (ram_wen=0) while stalled.
- Back-to-back throughput: one request per 3 (store) / 4 (load) cycles.

## Structure
- Shared package lsu_pkg: size encodings SZ_B/SZ_H/SZ_W/SZ_D, state enum, helper constant for byte-offset width (3).
- Sub-module lsu_align: purely combinational. Takes off/size/unsigned/wdata/rdata and produces wstrb, shifted wdata, and extended load. Used by both paths.
- The top module holds the FSM and latches.

## Test plan
- Store B at 0x8000_0003, wdata 0xAB → one cycle ram_wen=1, waddr 0x8000_0000, wstrb 0x08, wdata 0xAB00_0000. resp_valid at T+2, err=0.
- Load H signed at 0x8000_0006, ram_rdata 0x8001_0000_0000_0000 → resp_rdata 0xFFFF_FFFF_FFFF_8001 at T+3. Unsigned variant → 0x8001.
- Load W at 0x8000_0002 → resp_err=1 at T+1. ram_wen never asserted, raddr unchanged.
- Load D at 0x8000_0008 with resp_ready held low 5 cycles → resp_valid and data stable throughout. req_ready=0 until the handshake completes.
- Reset asserted during ISSUE of a store → ram_wen=0 that cycle. IDLE next cycle, no response.
- Back-to-back store then load to the same word → load returns the stored bytes; req_ready low while busy.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the LSU RAM master and its byte-lane aligner.
package lsu_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned OFF_W   = 3;
    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned STATE_W = 2;

    typedef logic [SIZE_W-1:0] size_t;

    localparam size_t SZ_B = 2'd0;
    localparam size_t SZ_H = 2'd1;
    localparam size_t SZ_W = 2'd2;
    localparam size_t SZ_D = 2'd3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Low-offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [OFF_W-1:0] size_mask(input size_t size);
        logic [OFF_W-1:0] mask;
        mask = '0;
        case (size)
            SZ_B:    mask = 3'b000;
            SZ_H:    mask = 3'b001;
            SZ_W:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(input logic [OFF_W-1:0] off, input size_t size);
        return (off & size_mask(size)) != '0;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane aligner: store strobes/data placement and load extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [OFF_W-1:0]  off_i,
    input  size_t             size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] load_o
);

    localparam int unsigned SHIFT_W = OFF_W + 3;

    logic [SHIFT_W-1:0] bit_shift;
    logic [STRB_W-1:0]  base_strb;
    logic [DATA_W-1:0]  raw;
    logic               sext;

    assign bit_shift = {off_i, 3'b000};
    assign wdata_o   = wdata_i << bit_shift;
    assign raw       = rdata_i >> bit_shift;
    assign wstrb_o   = base_strb << off_i;
    assign sext      = !unsigned_i;

    // Doubleword loads never extend, so the raw lane data passes through.
    always_comb begin
        base_strb = '0;
        load_o    = raw;
        case (size_i)
            SZ_B: begin
                base_strb = STRB_W'(8'h01);
                load_o    = {{(DATA_W-8){sext & raw[7]}}, raw[7:0]};
            end
            SZ_H: begin
                base_strb = STRB_W'(8'h03);
                load_o    = {{(DATA_W-16){sext & raw[15]}}, raw[15:0]};
            end
            SZ_W: begin
                base_strb = STRB_W'(8'h0F);
                load_o    = {{(DATA_W-32){sext & raw[31]}}, raw[31:0]};
            end
            default: begin
                base_strb = STRB_W'(8'hFF);
                load_o    = raw;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ram_master.sv
// Single-outstanding load/store initiator for the 64-bit, 8-byte-aligned simulation RAM port.
module lsu_ram_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [STRB_W-1:0] ram_wstrb,
    output logic              ram_wen
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OFF_W-1:0]  off_q, off_d;
    size_t             size_q, size_d;
    logic              uns_q, uns_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              resp_valid_q, resp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              ram_wen_q, ram_wen_d;

    logic              use_req;
    logic              req_misaligned;
    logic [OFF_W-1:0]  al_off;
    size_t             al_size;
    logic              al_uns;
    logic [STRB_W-1:0] al_wstrb;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_load;

    // In IDLE the aligner sees the incoming request; afterwards it sees the latched one.
    assign use_req        = (state_q == ST_IDLE);
    assign al_off         = use_req ? req_addr[OFF_W-1:0] : off_q;
    assign al_size        = use_req ? req_size : size_q;
    assign al_uns         = use_req ? req_unsigned : uns_q;
    assign req_misaligned = is_misaligned(req_addr[OFF_W-1:0], req_size);

    lsu_align u_align (
        .off_i      (al_off),
        .size_i     (al_size),
        .unsigned_i (al_uns),
        .wdata_i    (req_wdata),
        .rdata_i    (ram_rdata),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .load_o     (al_load)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        ram_wen_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d   = req_addr[OFF_W-1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wen_d   = req_wen;
                    err_d   = req_misaligned;
                    rdata_d = '0;
                    if (req_misaligned) begin
                        state_d = ST_RESP;
                    end else begin
                        // Address and lane data only move for accesses that reach the RAM.
                        addr_d    = req_addr & ~ADDR_W'(7);
                        wdata_d   = al_wdata;
                        wstrb_d   = al_wstrb;
                        ram_wen_d = req_wen;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = wen_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                rdata_d = al_load;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        resp_valid_d = (state_d == ST_RESP);
        req_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            off_q        <= '0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            ram_wen_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            ram_wen_q    <= ram_wen_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign ram_raddr  = addr_q;
    assign ram_waddr  = addr_q;
    assign ram_wdata  = wdata_q;
    // A write must never commit in a reset cycle, even when reset lands during ISSUE.
    assign ram_wen    = ram_wen_q & ~reset;
    assign ram_wstrb  = ram_wen ? wstrb_q : '0;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Bench for lsu_ram_master: byte-level reference memory, word RAM responder, directed and random requests.
module tb_lsu_ram_master;
    import lsu_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned WORDS = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] ram_raddr;
    logic [63:0] ram_rdata;
    logic [63:0] ram_waddr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_wstrb;
    logic        ram_wen;

    int checks = 0;
    int errors = 0;

    logic [63:0] ram [WORDS];
    logic [7:0]  ref_mem [WORDS*8];
    int          wen_count = 0;
    int          strb_leak = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [63:0] last_waddr, last_wdata;
    logic [7:0]  last_wstrb;

    lsu_ram_master #(.ADDR_W(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_wstrb    (ram_wstrb),
        .ram_wen      (ram_wen)
    );

    always #5 clock = ~clock;

    function automatic int widx(input logic [63:0] a);
        return int'(((a - BASE) >> 3) & 64'(WORDS - 1));
    endfunction

    // RAM responder: read data one cycle after the address, strobed writes on ram_wen.
    always @(posedge clock) begin
        cyc       <= cyc + 1;
        ram_rdata <= ram[widx(ram_raddr)];
        if (ram_wen === 1'b1) begin
            wen_count  <= wen_count + 1;
            last_waddr <= ram_waddr;
            last_wdata <= ram_wdata;
            last_wstrb <= ram_wstrb;
            for (int b = 0; b < 8; b++)
                if (ram_wstrb[b]) ram[widx(ram_waddr)][8*b +: 8] <= ram_wdata[8*b +: 8];
        end else if (ram_wstrb !== 8'h00) begin
            strb_leak <= strb_leak + 1;
        end
    end

    function automatic logic [63:0] ref_load(input logic [63:0] a, input int sz, input bit uns);
        int n;
        int base;
        logic [63:0] v;
        n    = 1 << sz;
        base = int'(a - BASE);
        v    = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[base + i]) << (8 * i));
        if (!uns && sz != 3 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input int sz, input logic [63:0] d);
        int base;
        base = int'(a - BASE);
        for (int i = 0; i < (1 << sz); i++) ref_mem[base + i] = d[8*i +: 8];
    endtask

    task automatic preset(input int w, input logic [63:0] val);
        ram[w] <= val;
        for (int b = 0; b < 8; b++) ref_mem[w*8 + b] = val[8*b +: 8];
    endtask

    // Presents one request and returns #1 after the accepting edge.
    task automatic issue(input logic [63:0] a, input bit w, input logic [1:0] s,
                         input bit u, input logic [63:0] d);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL issue_timeout req_ready=%b after %0d cycles", req_ready, n);
        end
        req_valid    = 1'b1;
        req_addr     = a;
        req_wen      = w;
        req_size     = s;
        req_unsigned = u;
        req_wdata    = d;
        @(posedge clock); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input bit consume, output int lat, output logic [63:0] rd, output logic er);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        if (resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL resp_timeout resp_valid=%b after %0d cycles", resp_valid, lat);
        end
        rd = resp_rdata;
        er = resp_err;
        if (consume) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, ram_wen, ram_wstrb} !== {4'b1000, 8'h00}) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/vld/err/wen/strb=%b %b %b %b %h exp 1 0 0 0 00",
                     req_ready, resp_valid, resp_err, ram_wen, ram_wstrb);
        end
        checks++;
        if ({resp_rdata, ram_raddr, ram_waddr, ram_wdata} !== 256'd0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h raddr=%h waddr=%h wdata=%h exp all 0",
                     resp_rdata, ram_raddr, ram_waddr, ram_wdata);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_store_byte();
        int lat, wen0;
        logic [63:0] rd;
        logic er;
        wen0 = wen_count;
        issue(64'h8000_0003, 1'b1, SZ_B, 1'b0, 64'hAB);
        checks++;
        if ({ram_wen, ram_waddr, ram_wstrb, ram_wdata} !== {1'b1, 64'h8000_0000, 8'h08, 64'hAB00_0000}) begin
            errors++;
            $display("FAIL store_b_port got wen=%b waddr=%h strb=%h wdata=%h exp 1 80000000 08 ab000000",
                     ram_wen, ram_waddr, ram_wstrb, ram_wdata);
        end
        wait_resp(1'b1, lat, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 64'd0) begin
            errors++;
            $display("FAIL store_b_resp got lat=%0d err=%b rdata=%h exp 2 0 0", lat, er, rd);
        end
        checks++;
        if (wen_count - wen0 != 1) begin
            errors++;
            $display("FAIL store_b_wen_cycles got %0d exp 1", wen_count - wen0);
        end
        ref_store(64'h8000_0003, 0, 64'hAB);
    endtask

    task automatic test_load_half();
        int lat;
        logic [63:0] rd;
        logic er;
        preset(0, 64'h8001_0000_0000_0000);
        issue(64'h8000_0006, 1'b0, SZ_H, 1'b0, 64'd0);
        wait_resp(1'b1, lat, rd, er);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 64'hFFFF_FFFF_FFFF_8001) begin
            errors++;
            $display("FAIL load_h_signed got lat=%0d err=%b rdata=%h exp 3 0 ffffffffffff8001", lat, er, rd);
        end
        issue(64'h8000_0006, 1'b0, SZ_H, 1'b1, 64'd0);
        wait_resp(1'b1, lat, rd, er);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 64'h8001) begin
            errors++;
            $display("FAIL load_h_unsigned got lat=%0d err=%b rdata=%h exp 3 0 8001", lat, er, rd);
        end
    endtask

    task automatic test_misaligned();
        int lat, wen0;
        logic [63:0] rd, raddr0;
        logic er;
        wen0   = wen_count;
        raddr0 = ram_raddr;
        issue(64'h8000_0002, 1'b0, SZ_W, 1'b0, 64'd0);
        wait_resp(1'b1, lat, rd, er);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 64'd0) begin
            errors++;
            $display("FAIL misaligned_resp got lat=%0d err=%b rdata=%h exp 1 1 0", lat, er, rd);
        end
        checks++;
        if (ram_raddr !== raddr0 || wen_count != wen0) begin
            errors++;
            $display("FAIL misaligned_quiet got raddr=%h wen_cycles=%0d exp %h 0",
                     ram_raddr, wen_count - wen0, raddr0);
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [63:0] rd, v;
        logic er;
        v = {$urandom, $urandom};
        preset(1, v);
        resp_ready = 1'b0;
        issue(64'h8000_0008, 1'b0, SZ_D, 1'b0, 64'd0);
        wait_resp(1'b0, lat, rd, er);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== v) begin
            errors++;
            $display("FAIL stall_load_d got lat=%0d err=%b rdata=%h exp 3 0 %h", lat, er, rd, v);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== v || req_ready !== 1'b0 || ram_wen !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d got vld=%b rdata=%h rdy=%b wen=%b exp 1 %h 0 0",
                         i, resp_valid, resp_rdata, req_ready, ram_wen, v);
            end
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got vld=%b rdy=%b exp 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int wen0, lat;
        bit seen;
        logic [63:0] rd;
        logic er;
        wen0 = wen_count;
        issue(64'h8000_0010, 1'b1, SZ_D, 1'b0, {$urandom, $urandom});
        reset = 1'b1;
        #1;
        checks++;
        if (ram_wen !== 1'b0 || ram_wstrb !== 8'h00) begin
            errors++;
            $display("FAIL reset_issue_wen got wen=%b strb=%h exp 0 00", ram_wen, ram_wstrb);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || wen_count != wen0) begin
            errors++;
            $display("FAIL reset_mid_idle got rdy=%b vld=%b wen_cycles=%0d exp 1 0 0",
                     req_ready, resp_valid, wen_count - wen0);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_noresp got a response exp none");
        end
        issue(64'h8000_0010, 1'b0, SZ_D, 1'b0, 64'd0);
        wait_resp(1'b1, lat, rd, er);
        checks++;
        if (rd !== ref_load(64'h8000_0010, 3, 1'b0) || er !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mem got %h err=%b exp %h 0", rd, er, ref_load(64'h8000_0010, 3, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        int lat, s_acc, l_acc;
        logic [63:0] a, d, rd, exp;
        logic er;
        bit un;
        a  = BASE + 64'($urandom_range(3, WORDS - 1) * 8) + (($urandom_range(0, 1) == 1) ? 64'd4 : 64'd0);
        d  = {$urandom, $urandom};
        un = 1'($urandom_range(0, 1));
        issue(a, 1'b1, SZ_W, 1'b0, d);
        s_acc = acc_cyc;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy got req_ready=%b exp 0", req_ready);
        end
        wait_resp(1'b1, lat, rd, er);
        ref_store(a, 2, d);
        issue(a, 1'b0, SZ_W, un, 64'd0);
        l_acc = acc_cyc;
        checks++;
        if (l_acc - s_acc != 3) begin
            errors++;
            $display("FAIL b2b_store_period got %0d exp 3", l_acc - s_acc);
        end
        wait_resp(1'b1, lat, rd, er);
        exp = un ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
        checks++;
        if (rd !== exp || lat != 3) begin
            errors++;
            $display("FAIL b2b_load_data got %h lat=%0d exp %h 3", rd, lat, exp);
        end
        issue(a, 1'b1, SZ_B, 1'b0, 64'h5A);
        checks++;
        if (acc_cyc - l_acc != 4) begin
            errors++;
            $display("FAIL b2b_load_period got %0d exp 4", acc_cyc - l_acc);
        end
        wait_resp(1'b1, lat, rd, er);
        ref_store(a, 0, 64'h5A);
    endtask

    task automatic test_random();
        logic [63:0] a, d, rd, exp_rd, exp_wd, lmask;
        logic [7:0]  exp_strb;
        logic [2:0]  off, m;
        logic        er;
        int          s, w, lat, exp_lat, wen0;
        bit          st, un, mis;
        for (int it = 0; it < 80; it++) begin
            s   = int'($urandom_range(0, 3));
            w   = int'($urandom_range(0, WORDS - 1));
            st  = 1'($urandom_range(0, 1));
            un  = 1'($urandom_range(0, 1));
            d   = {$urandom, $urandom};
            m   = 3'((1 << s) - 1);
            mis = (s != 0) && ($urandom_range(0, 5) == 0);
            if (mis) begin
                do off = 3'($urandom); while ((off & m) == 3'd0);
            end else begin
                off = 3'($urandom) & ~m;
            end
            a        = BASE + 64'(w * 8) + 64'(off);
            exp_lat  = mis ? 1 : (st ? 2 : 3);
            exp_rd   = (mis || st) ? 64'd0 : ref_load(a, s, un);
            exp_strb = '0;
            exp_wd   = '0;
            lmask    = '0;
            if (!mis) begin
                for (int i = 0; i < (1 << s); i++) begin
                    exp_strb[int'(off) + i]          = 1'b1;
                    exp_wd[8*(int'(off) + i) +: 8]   = d[8*i +: 8];
                    lmask[8*(int'(off) + i) +: 8]    = 8'hFF;
                end
            end
            wen0 = wen_count;
            issue(a, st, 2'(s), un, d);
            wait_resp(1'b1, lat, rd, er);
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL rand_lat_%0d addr=%h wen=%b size=%0d got %0d exp %0d", it, a, st, s, lat, exp_lat);
            end
            checks++;
            if ({er, rd} !== {mis, exp_rd}) begin
                errors++;
                $display("FAIL rand_resp_%0d addr=%h wen=%b size=%0d uns=%b got err=%b rdata=%h exp %b %h",
                         it, a, st, s, un, er, rd, mis, exp_rd);
            end
            checks++;
            if (st && !mis) begin
                ref_store(a, s, d);
                if (wen_count - wen0 != 1 || last_waddr !== (a & ~64'd7) || last_wstrb !== exp_strb ||
                    (last_wdata & lmask) !== exp_wd) begin
                    errors++;
                    $display("FAIL rand_write_%0d got n=%0d waddr=%h strb=%h wdata=%h exp 1 %h %h %h",
                             it, wen_count - wen0, last_waddr, last_wstrb, last_wdata & lmask,
                             a & ~64'd7, exp_strb, exp_wd);
                end
            end else if (wen_count != wen0) begin
                errors++;
                $display("FAIL rand_nowrite_%0d got %0d write cycles exp 0", it, wen_count - wen0);
            end
        end
    endtask

    task automatic test_quiet_port();
        checks++;
        if (strb_leak != 0) begin
            errors++;
            $display("FAIL strb_without_wen got %0d cycles exp 0", strb_leak);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_wen      = 1'b0;
        req_size     = SZ_B;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        for (int w = 0; w < int'(WORDS); w++) preset(w, {$urandom, $urandom});

        test_reset();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_quiet_port();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
